// File: rtl/uart_tx_ctrl.sv
// UART transmitter: start bit, 8 data bits LSB-first, optional even/odd parity, 1 or 2 stop bits.
// Latency: the start bit is on the line the cycle after a byte is accepted; frame = (1+8+USE_PARITY+STOP_BITS)*BAUD_CLKS.
// Backpressure: tx_ready only in IDLE or the final stop cycle; tx_valid is ignored otherwise and nothing is buffered.
module uart_tx_ctrl #(
  parameter int CLK_FREQ_HZ = 100000000,
  parameter int BAUD_RATE   = 115200,
  parameter int USE_PARITY  = 1,
  parameter int ODD_PARITY  = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       uart_tx_out,
  output logic       busy
);

  localparam int BAUD_CLKS = CLK_FREQ_HZ / BAUD_RATE;
  localparam int CNT_W     = (BAUD_CLKS > 1) ? $clog2(BAUD_CLKS) : 1;

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_CLKS - 1);
  localparam logic             STOP_LAST = (STOP_BITS == 2);
  localparam logic             USE_PAR   = (USE_PARITY != 0);
  localparam logic             ODD_PAR   = (ODD_PARITY != 0);

  // Reject parameter sets that cannot produce a legal frame.
  generate
    if (BAUD_CLKS < 2) begin : g_bad_baud
      $error("uart_tx_ctrl: CLK_FREQ_HZ/BAUD_RATE must be at least 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
      $error("uart_tx_ctrl: STOP_BITS must be 1 or 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t           state,     state_nxt;
  logic [CNT_W-1:0] baud_cnt,  baud_nxt;
  logic [2:0]       bit_cnt,   bit_nxt;
  logic             stop_cnt,  stop_nxt;
  logic [7:0]       shift_reg, shift_nxt;
  logic             parity,    parity_nxt;
  logic             line_nxt;
  logic             baud_last;
  logic             accept;

  // Ready is decoded from registered state only, so it never depends on tx_valid.
  assign tx_ready  = (state == S_IDLE) ||
                     (state == S_STOP && baud_cnt == BAUD_LAST && stop_cnt == STOP_LAST);
  assign busy      = (state != S_IDLE);
  assign baud_last = (baud_cnt == BAUD_LAST);
  assign accept    = tx_valid && tx_ready;

  // Next-state, counters, shifter and the value the line will carry next cycle.
  always_comb begin
    state_nxt  = state;
    baud_nxt   = baud_cnt;
    bit_nxt    = bit_cnt;
    stop_nxt   = stop_cnt;
    shift_nxt  = shift_reg;
    parity_nxt = parity;
    line_nxt   = 1'b1;

    case (state)
      S_IDLE: begin
        if (accept) state_nxt = S_START;
      end
      S_START: begin
        if (baud_last) begin
          baud_nxt  = '0;
          state_nxt = S_DATA;
        end else begin
          baud_nxt = baud_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (baud_last) begin
          baud_nxt   = '0;
          parity_nxt = parity ^ shift_reg[0];
          shift_nxt  = {1'b0, shift_reg[7:1]};
          if (bit_cnt == 3'd7) begin
            bit_nxt   = '0;
            stop_nxt  = 1'b0;
            state_nxt = USE_PAR ? S_PARITY : S_STOP;
          end else begin
            bit_nxt = bit_cnt + 1'b1;
          end
        end else begin
          baud_nxt = baud_cnt + 1'b1;
        end
      end
      S_PARITY: begin
        if (baud_last) begin
          baud_nxt  = '0;
          stop_nxt  = 1'b0;
          state_nxt = S_STOP;
        end else begin
          baud_nxt = baud_cnt + 1'b1;
        end
      end
      S_STOP: begin
        if (baud_last) begin
          baud_nxt = '0;
          if (stop_cnt == STOP_LAST) begin
            state_nxt = accept ? S_START : S_IDLE;
          end else begin
            stop_nxt = stop_cnt + 1'b1;
          end
        end else begin
          baud_nxt = baud_cnt + 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    // A new byte restarts every per-frame register, from IDLE or the last stop cycle alike.
    if (accept) begin
      shift_nxt  = tx_data;
      parity_nxt = 1'b0;
      baud_nxt   = '0;
      bit_nxt    = '0;
      stop_nxt   = 1'b0;
    end

    // The line is registered, so it is driven from where the FSM is going, not where it is.
    case (state_nxt)
      S_START:  line_nxt = 1'b0;
      S_DATA:   line_nxt = shift_nxt[0];
      S_PARITY: line_nxt = parity_nxt ^ ODD_PAR;
      default:  line_nxt = 1'b1;
    endcase
  end

  // State, counters, data and the registered serial line; reset forces the line high at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      baud_cnt    <= '0;
      bit_cnt     <= '0;
      stop_cnt    <= 1'b0;
      shift_reg   <= '0;
      parity      <= 1'b0;
      uart_tx_out <= 1'b1;
    end else begin
      state       <= state_nxt;
      baud_cnt    <= baud_nxt;
      bit_cnt     <= bit_nxt;
      stop_cnt    <= stop_nxt;
      shift_reg   <= shift_nxt;
      parity      <= parity_nxt;
      uart_tx_out <= line_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: default, odd-parity and no-parity instances on one clock.
// A line monitor per instance decodes frames against a queue of expected bytes.
// Each scenario task drives stimulus and compares timing and line values inline.
`timescale 1ns/1ps
module tb_uart_tx_ctrl;

  localparam int B = 868;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_v [3];
  logic [2:0] valid_v;
  wire  [2:0] ready_v;
  wire  [2:0] line_v;
  wire  [2:0] busy_v;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] exp_q [3][$];

  always #5 clk = ~clk;

  uart_tx_ctrl u_dut (
    .clk(clk), .rst(rst), .tx_data(data_v[0]), .tx_valid(valid_v[0]),
    .tx_ready(ready_v[0]), .uart_tx_out(line_v[0]), .busy(busy_v[0])
  );

  uart_tx_ctrl #(.ODD_PARITY(1)) u_odd (
    .clk(clk), .rst(rst), .tx_data(data_v[1]), .tx_valid(valid_v[1]),
    .tx_ready(ready_v[1]), .uart_tx_out(line_v[1]), .busy(busy_v[1])
  );

  uart_tx_ctrl #(.USE_PARITY(0)) u_nopar (
    .clk(clk), .rst(rst), .tx_data(data_v[2]), .tx_valid(valid_v[2]),
    .tx_ready(ready_v[2]), .uart_tx_out(line_v[2]), .busy(busy_v[2])
  );

  // Line monitors: detect start, sample mid-bit, check framing and parity, compare with the queue.
  for (genvar g = 0; g < 3; g++) begin : g_mon
    localparam int   NB  = (g == 2) ? 10 : 11;
    localparam logic PAR = (g != 2);
    localparam logic ODD = (g == 1);
    int          cnt;
    bit          act;
    logic [10:0] bits;
    logic [7:0]  d;
    logic [7:0]  e;
    logic        ok;
    initial begin
      act = 1'b0;
      cnt = 0;
      forever begin
        @(negedge clk);
        if (rst === 1'b1) begin
          act = 1'b0;
        end else if (!act) begin
          if (line_v[g] === 1'b0) begin
            act  = 1'b1;
            cnt  = 0;
            bits = '0;
          end
        end else begin
          cnt++;
          if (cnt % B == B / 2) bits[cnt / B] = line_v[g];
          if (cnt == (NB - 1) * B + B / 2) begin
            act = 1'b0;
            d   = bits[8:1];
            ok  = (bits[0] === 1'b0) && (bits[NB-1] === 1'b1) &&
                  (!PAR || bits[9] === ((^d) ^ ODD));
            if (d >= 8'h20 && d < 8'h7f)
              $display("mon%0d: byte 0x%02h '%c' framing_ok=%0d", g, d, d, ok);
            else
              $display("mon%0d: byte 0x%02h framing_ok=%0d", g, d, ok);
            n_chk++;
            if (exp_q[g].size() == 0) begin
              $display("FAIL mon%0d_unexpected_frame: got 0x%02h, required no frame", g, d);
            end else begin
              e = exp_q[g].pop_front();
              if (!ok || d !== e)
                $display("FAIL mon%0d_frame: got 0x%02h framing_ok=%0d, required 0x%02h framing_ok=1",
                         g, d, ok, e);
              else
                n_pass++;
            end
          end
        end
      end
    end
  end

  // Offer one byte for one cycle and record it as expected; returns #1 after the acceptance edge.
  task automatic send(input int k, input logic [7:0] b);
    data_v[k]  = b;
    valid_v[k] = 1'b1;
    exp_q[k].push_back(b);
    @(posedge clk); #1;
    valid_v[k] = 1'b0;
  endtask

  task automatic test_reset();
    int bad_line = 0;
    int bad_rdy  = 0;
    int bad_busy = 0;
    rst     = 1'b1;
    valid_v = '0;
    for (int k = 0; k < 3; k++) data_v[k] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      n_chk++;
      if ({line_v[k], ready_v[k], busy_v[k]} !== 3'b110)
        $display("FAIL reset_state dut%0d: line/ready/busy=%b, required 110", k,
                 {line_v[k], ready_v[k], busy_v[k]});
      else
        n_pass++;
    end
    rst = 1'b0;
    for (int n = 0; n < 20000; n++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin
        if (line_v[k] !== 1'b1)  bad_line++;
        if (ready_v[k] !== 1'b1) bad_rdy++;
        if (busy_v[k] !== 1'b0)  bad_busy++;
      end
    end
    n_chk++;
    if (bad_line != 0) $display("FAIL idle_line: %0d bad cycles, required 0", bad_line);
    else n_pass++;
    n_chk++;
    if (bad_rdy != 0) $display("FAIL idle_ready: %0d bad cycles, required 0", bad_rdy);
    else n_pass++;
    n_chk++;
    if (bad_busy != 0) $display("FAIL idle_busy: %0d bad cycles, required 0", bad_busy);
    else n_pass++;
  endtask

  task automatic test_frame_41();
    logic [7:0]  b = 8'h41;
    logic [10:0] fb;
    int bad_line = 0;
    int rdy_low  = 0;
    int bad_busy = 0;
    logic rdy_last = 1'bx;
    fb = {1'b1, ^b, b, 1'b0};
    send(0, b);
    for (int n = 0; n < 11 * B; n++) begin
      if (line_v[0] !== fb[n / B]) bad_line++;
      if (ready_v[0] === 1'b0) rdy_low++;
      if (busy_v[0] !== 1'b1) bad_busy++;
      if (n == 11 * B - 1) rdy_last = ready_v[0];
      @(posedge clk); #1;
    end
    n_chk++;
    if (bad_line != 0) $display("FAIL frame41_line: %0d cycles off waveform, required 0", bad_line);
    else n_pass++;
    n_chk++;
    if (rdy_low != 11 * B - 1) $display("FAIL frame41_ready_low: %0d cycles, required %0d", rdy_low, 11 * B - 1);
    else n_pass++;
    n_chk++;
    if (rdy_last !== 1'b1) $display("FAIL frame41_ready_last_stop: %b, required 1", rdy_last);
    else n_pass++;
    n_chk++;
    if (bad_busy != 0) $display("FAIL frame41_busy: %0d cycles low, required 0", bad_busy);
    else n_pass++;
    n_chk++;
    if ({line_v[0], ready_v[0], busy_v[0]} !== 3'b110)
      $display("FAIL frame41_idle_after: line/ready/busy=%b, required 110", {line_v[0], ready_v[0], busy_v[0]});
    else n_pass++;
  endtask

  task automatic test_parity_variants();
    int   n_even = 0;
    int   n_odd  = 0;
    int   n_np   = 0;
    int   rdy_np = -1;
    logic par_even = 1'bx;
    logic par_odd  = 1'bx;
    fork
      begin
        send(0, 8'h07);
        while (busy_v[0] === 1'b1 && n_even < 30000) begin
          if (n_even == 9 * B + B / 2) par_even = line_v[0];
          @(posedge clk); #1;
          n_even++;
        end
      end
      begin
        send(1, 8'h00);
        while (busy_v[1] === 1'b1 && n_odd < 30000) begin
          if (n_odd == 9 * B + B / 2) par_odd = line_v[1];
          @(posedge clk); #1;
          n_odd++;
        end
      end
      begin
        send(2, 8'hC3);
        while (busy_v[2] === 1'b1 && n_np < 30000) begin
          if (ready_v[2] === 1'b1 && rdy_np < 0) rdy_np = n_np;
          @(posedge clk); #1;
          n_np++;
        end
      end
    join
    n_chk++;
    if (par_even !== 1'b1) $display("FAIL even_parity_07: parity bit %b, required 1", par_even);
    else n_pass++;
    n_chk++;
    if (par_odd !== 1'b1) $display("FAIL odd_parity_00: parity bit %b, required 1", par_odd);
    else n_pass++;
    n_chk++;
    if (n_odd != 11 * B) $display("FAIL odd_frame_len: %0d cycles, required %0d", n_odd, 11 * B);
    else n_pass++;
    n_chk++;
    if (n_np != 10 * B) $display("FAIL nopar_frame_len: %0d cycles, required %0d", n_np, 10 * B);
    else n_pass++;
    n_chk++;
    if (rdy_np != 10 * B - 1) $display("FAIL nopar_ready_at: cycle %0d, required %0d", rdy_np, 10 * B - 1);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int   n      = 0;
    int   rdy_at = -1;
    logic line2  = 1'bx;
    data_v[0]  = 8'h55;
    valid_v[0] = 1'b1;
    exp_q[0].push_back(8'h55);
    @(posedge clk); #1;
    data_v[0] = 8'hAA;
    exp_q[0].push_back(8'hAA);
    while (busy_v[0] === 1'b1 && n < 40000) begin
      if (ready_v[0] === 1'b1 && rdy_at < 0) rdy_at = n;
      if (n == 11 * B) line2 = line_v[0];
      @(posedge clk); #1;
      n++;
      if (rdy_at >= 0) valid_v[0] = 1'b0;
    end
    valid_v[0] = 1'b0;
    n_chk++;
    if (rdy_at != 11 * B - 1) $display("FAIL b2b_ready_at: cycle %0d, required %0d", rdy_at, 11 * B - 1);
    else n_pass++;
    n_chk++;
    if (line2 !== 1'b0) $display("FAIL b2b_second_start: line %b at cycle %0d, required 0", line2, 11 * B);
    else n_pass++;
    n_chk++;
    if (n != 22 * B) $display("FAIL b2b_span: %0d busy cycles, required %0d", n, 22 * B);
    else n_pass++;
  endtask

  task automatic test_ignore_midframe();
    int n       = 0;
    int rdy_hi  = 0;
    int busy_hi = 0;
    send(0, 8'h12);
    while (busy_v[0] === 1'b1 && n < 30000) begin
      if (n < 11 * B - 1 && ready_v[0] === 1'b1) rdy_hi++;
      if (n == 3000) begin
        data_v[0]  = 8'hFF;
        valid_v[0] = 1'b1;
      end
      if (n == 3001) valid_v[0] = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    valid_v[0] = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (busy_v[0] !== 1'b0) busy_hi++;
      @(posedge clk); #1;
    end
    n_chk++;
    if (rdy_hi != 0) $display("FAIL midframe_ready: high %0d cycles mid-frame, required 0", rdy_hi);
    else n_pass++;
    n_chk++;
    if (n != 11 * B) $display("FAIL midframe_len: %0d cycles, required %0d", n, 11 * B);
    else n_pass++;
    n_chk++;
    if (busy_hi != 0) $display("FAIL midframe_no_extra_frame: busy %0d cycles after, required 0", busy_hi);
    else n_pass++;
  endtask

  task automatic test_reset_midframe();
    int   n     = 0;
    int   lows  = 0;
    logic pre   = 1'bx;
    data_v[0]  = 8'h30;
    valid_v[0] = 1'b1;
    @(posedge clk); #1;
    valid_v[0] = 1'b0;
    repeat (4 * B + B / 2) @(posedge clk);
    #1;
    pre = line_v[0];
    rst = 1'b1;
    @(posedge clk); #1;
    n_chk++;
    if (pre !== 1'b0) $display("FAIL rst_pre_bit3: line %b, required 0", pre);
    else n_pass++;
    n_chk++;
    if ({line_v[0], ready_v[0], busy_v[0]} !== 3'b110)
      $display("FAIL rst_abort: line/ready/busy=%b, required 110", {line_v[0], ready_v[0], busy_v[0]});
    else n_pass++;
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (line_v[0] !== 1'b1) lows++;
      @(posedge clk); #1;
    end
    n_chk++;
    if (lows != 0) $display("FAIL rst_no_glitch: line low %0d cycles, required 0", lows);
    else n_pass++;
    send(0, 8'h0D);
    while (busy_v[0] === 1'b1 && n < 30000) begin
      @(posedge clk); #1;
      n++;
    end
    n_chk++;
    if (n != 11 * B) $display("FAIL rst_next_frame_len: %0d cycles, required %0d", n, 11 * B);
    else n_pass++;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("%0d/%0d checks passed", n_pass, n_chk + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_frame_41();
    test_parity_variants();
    test_back_to_back();
    test_ignore_midframe();
    test_reset_midframe();
    repeat (10) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      n_chk++;
      if (exp_q[k].size() != 0)
        $display("FAIL sb_drain dut%0d: %0d frames undecoded, required 0", k, exp_q[k].size());
      else
        n_pass++;
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
